// File: rtl/axi_wr_slave_responder.sv
// -----------------------------------------------------------------------------
// axi_wr_slave_responder
//
// AXI write-channel slave. It accepts one burst at a time on AW/W, writes the
// strobed data into an internal word memory and returns one B response per
// burst. The burst length comes from AWLEN; WLAST is only checked for
// consistency with it.
//
// Optional build macro: AXI_WR_SLAVE_BP_EN
//   When defined, the block applies backpressure. AWREADY waits until AWVALID
//   has been seen for two consecutive cycles, and WREADY toggles 0,1,0,1...
//   during the data phase.
//   When undefined, AWREADY is held high in IDLE and WREADY is held high in
//   DATA.
//
// Ports
//   aclk, areset        clock, synchronous active-high reset
//   aw*                 write address channel (awid/awaddr/awlen/awsize/awburst)
//   w*                  write data channel (wdata/wstrb/wlast)
//   b*                  write response channel (bid/bresp)
//   dbg_addr/dbg_rdata  combinational word readback of the memory
// -----------------------------------------------------------------------------
module axi_wr_slave_responder #(
    parameter int ID_W      = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 256
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [ID_W-1:0]              awid,
    input  logic [ADDR_W-1:0]            awaddr,
    input  logic [7:0]                   awlen,
    input  logic [2:0]                   awsize,
    input  logic [1:0]                   awburst,
    input  logic                         wvalid,
    output logic                         wready,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [DATA_W/8-1:0]          wstrb,
    input  logic                         wlast,
    output logic                         bvalid,
    input  logic                         bready,
    output logic [ID_W-1:0]              bid,
    output logic [1:0]                   bresp,
    input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
    output logic [DATA_W-1:0]            dbg_rdata
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int NB = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t              r_state;
    logic                r_awready;
    logic                r_wready;
    logic                r_bvalid;
    logic [ID_W-1:0]     r_bid;
    logic [1:0]          r_bresp;

    // Captured burst context; these are data registers, so they are not reset.
    logic [ID_W-1:0]     r_id;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_len;
    logic [7:0]          r_beat;
    logic [2:0]          r_size;
    logic [1:0]          r_burst;
    logic                r_err;
`ifdef AXI_WR_SLAVE_BP_EN
    logic                r_aw_seen;
`endif

    logic [DATA_W-1:0]   r_mem [MEM_DEPTH];

    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_last_beat;
    logic                w_beat_err;
    logic                w_wlast_err;
    logic                w_wr_en;
    logic [AW-1:0]       w_word;

    assign w_aw_hs     = (r_state == IDLE) && awvalid && r_awready;
    assign w_w_hs      = (r_state == DATA) && wvalid && r_wready;
    assign w_last_beat = (r_beat == r_len);
    // Unsupported size, WRAP/reserved burst, or a byte address past the memory.
    assign w_beat_err  = (r_size != 3'b010) || r_burst[1] ||
                         (r_addr[ADDR_W-1:AW+2] != '0);
    assign w_wlast_err = (wlast != w_last_beat);
    assign w_wr_en     = w_w_hs && !w_beat_err && !areset;
    assign w_word      = r_addr[AW+1:2];

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state   <= IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bid     <= '0;
            r_bresp   <= 2'b00;
`ifdef AXI_WR_SLAVE_BP_EN
            r_aw_seen <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
`ifdef AXI_WR_SLAVE_BP_EN
                    // Ready only after AWVALID was seen on the previous cycle too.
                    r_aw_seen <= awvalid;
                    r_awready <= awvalid && r_aw_seen;
`else
                    r_awready <= 1'b1;
`endif
                    if (w_aw_hs) begin
                        r_state   <= DATA;
                        r_awready <= 1'b0;
`ifdef AXI_WR_SLAVE_BP_EN
                        r_aw_seen <= 1'b0;
                        r_wready  <= 1'b0;
`else
                        r_wready  <= 1'b1;
`endif
                        r_id      <= awid;
                        r_addr    <= awaddr;
                        r_len     <= awlen;
                        r_size    <= awsize;
                        r_burst   <= awburst;
                        r_beat    <= 8'd0;
                        r_err     <= 1'b0;
                    end
                end
                DATA: begin
`ifdef AXI_WR_SLAVE_BP_EN
                    r_wready <= ~r_wready;
`endif
                    if (w_w_hs) begin
                        r_beat <= r_beat + 8'd1;
                        if (r_burst != 2'b00)
                            r_addr <= r_addr + ADDR_W'(4);
                        if (w_beat_err || w_wlast_err)
                            r_err <= 1'b1;
                        if (w_last_beat) begin
                            r_state  <= RESP;
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bid    <= r_id;
                            r_bresp  <= (r_err || w_beat_err || w_wlast_err) ? 2'b10 : 2'b00;
                        end
                    end
                end
                RESP: begin
                    if (r_bvalid && bready) begin
                        r_bvalid <= 1'b0;
                        r_state  <= IDLE;
`ifndef AXI_WR_SLAVE_BP_EN
                        r_awready <= 1'b1;
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Byte-lane write; the memory deliberately has no reset.
    always_ff @(posedge aclk) begin
        if (w_wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wstrb[i])
                    r_mem[w_word][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    assign dbg_rdata = r_mem[dbg_addr];
    assign awready   = r_awready;
    assign wready    = r_wready;
    assign bvalid    = r_bvalid;
    assign bid       = r_bid;
    assign bresp     = r_bresp;

endmodule
